// File: rtl/count_clusters_pipe_pkg.sv
// Shared sizing helpers and default parameters for the pipelined VPF cluster counter.
// The cluster packer imports the same defaults.
package gem_cnt_pkg;

  localparam int N_VPFS_DFLT     = 1536;
  localparam int GROUP_DFLT      = 6;
  localparam int REG_STRIDE_DFLT = 2;
  localparam int OUT_W_DFLT      = 8;
  localparam int EVT_W_DFLT      = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int n_vpfs);
    return clog2(n_vpfs + 1);
  endfunction

  function automatic int tree_levels(input int n_vpfs, input int group);
    return clog2(n_vpfs / group);
  endfunction

  function automatic int pipe_latency(input int n_vpfs, input int group, input int stride);
    return (tree_levels(n_vpfs, group) + stride - 1) / stride + 1;
  endfunction

  // Bit offset of tree level lv inside the flattened tree vector; level j holds
  // 2^(levels-j) nodes of (leaf_w + j) bits each.
  function automatic int tree_offset(input int lv, input int levels, input int leaf_w);
    int off;
    off = 0;
    for (int j = 0; j < lv; j++) begin
      off = off + (1 << (levels - j)) * (leaf_w + j);
    end
    return off;
  endfunction

endpackage

// File: rtl/count_clusters_pipe_leaf.sv
// Combinational popcount of one GROUP-bit slice; forms level 0 of the adder tree.
module popcount_leaf
  import gem_cnt_pkg::*;
#(
  parameter int  GROUP = GROUP_DFLT,
  localparam int OUT_W = clog2(GROUP + 1)
) (
  input  logic [GROUP-1:0] flags,
  output logic [OUT_W-1:0] ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < GROUP; i++) begin
      ones = ones + OUT_W'(flags[i]);
    end
  end

endmodule

// File: rtl/count_clusters_pipe.sv
// Pipelined popcount of the per-BX VPF flags with threshold flag, saturating count,
// and peak / overflow-event statistics.
module count_clusters_pipe
  import gem_cnt_pkg::*;
#(
  parameter int  N_VPFS     = N_VPFS_DFLT,
  parameter int  GROUP      = GROUP_DFLT,
  parameter int  REG_STRIDE = REG_STRIDE_DFLT,
  parameter int  OUT_W      = OUT_W_DFLT,
  parameter int  EVT_W      = EVT_W_DFLT,
  localparam int CNT_W      = cnt_width(N_VPFS)
) (
  input  logic              clock4x,
  input  logic              reset_n,
  input  logic [N_VPFS-1:0] vpfs,
  input  logic              vpfs_valid,
  input  logic [CNT_W-1:0]  thresh,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  cnt,
  output logic [OUT_W-1:0]  cnt_sat,
  output logic              cnt_valid,
  output logic              overflow,
  output logic [CNT_W-1:0]  peak,
  output logic [EVT_W-1:0]  ovf_events
);

  localparam int LEAVES    = N_VPFS / GROUP;
  localparam int LEVELS    = tree_levels(N_VPFS, GROUP);
  localparam int PADDED    = 1 << LEVELS;
  localparam int LW        = clog2(GROUP + 1);
  localparam int LATENCY   = pipe_latency(N_VPFS, GROUP, REG_STRIDE);
  localparam int TREE_W    = LW + LEVELS;
  localparam int TREE_BITS = tree_offset(LEVELS + 1, LEVELS, LW);
  localparam int FINAL_OFF = tree_offset(LEVELS, LEVELS, LW);

  // Every tree level lives in one flat vector so each level can read its
  // predecessor by constant offset; all slices are driven by continuous assigns.
  logic [TREE_BITS-1:0] tree;

  for (genvar gi = 0; gi < PADDED; gi++) begin : g_leaf
    if (gi < LEAVES) begin : g_real
      popcount_leaf #(.GROUP(GROUP)) u_leaf (
        .flags(vpfs[gi*GROUP +: GROUP]),
        .ones (tree[gi*LW +: LW])
      );
    end else begin : g_pad
      assign tree[gi*LW +: LW] = '0;
    end
  end

  for (genvar gl = 1; gl <= LEVELS; gl++) begin : g_level
    localparam int  W       = LW + gl;
    localparam int  NODES   = PADDED >> gl;
    localparam int  IN_OFF  = tree_offset(gl - 1, LEVELS, LW);
    localparam int  OUT_OFF = tree_offset(gl, LEVELS, LW);
    localparam bit  IS_REG  = ((gl - 1) % REG_STRIDE == REG_STRIDE - 1) || (gl == LEVELS);

    logic [NODES*W-1:0] sum;

    for (genvar gi = 0; gi < NODES; gi++) begin : g_node
      assign sum[gi*W +: W] = {1'b0, tree[IN_OFF + (2*gi)*(W-1) +: W-1]}
                            + {1'b0, tree[IN_OFF + (2*gi+1)*(W-1) +: W-1]};
    end

    if (IS_REG) begin : g_reg
      logic [NODES*W-1:0] sum_reg;
      always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) sum_reg <= '0;
        else          sum_reg <= sum;
      end
      assign tree[OUT_OFF +: NODES*W] = sum_reg;
    end else begin : g_comb
      assign tree[OUT_OFF +: NODES*W] = sum;
    end
  end

  logic [TREE_W-1:0] sum_final;
  logic [CNT_W-1:0]  sum_next;
  logic [OUT_W-1:0]  sat_next;

  assign sum_final = tree[FINAL_OFF +: TREE_W];

  // The tree is wider than CNT_W only by headroom that a legal input never uses.
  if (TREE_W > CNT_W) begin : g_clip
    assign sum_next = (|sum_final[TREE_W-1:CNT_W]) ? '1 : sum_final[CNT_W-1:0];
  end else begin : g_noclip
    assign sum_next = sum_final;
  end

  if (CNT_W > OUT_W) begin : g_sat
    assign sat_next = (sum_next > {{(CNT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}})
                    ? '1 : sum_next[OUT_W-1:0];
  end else begin : g_nosat
    assign sat_next = OUT_W'(sum_next);
  end

  logic [LATENCY-2:0] valid_pipe_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [OUT_W-1:0]   cnt_sat_reg;
  logic               cnt_valid_reg;
  logic               overflow_reg;
  logic [CNT_W-1:0]   peak_reg;
  logic [EVT_W-1:0]   ovf_events_reg;

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      valid_pipe_reg <= '0;
      cnt_reg        <= '0;
      cnt_sat_reg    <= '0;
      cnt_valid_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      valid_pipe_reg <= (valid_pipe_reg << 1) | (LATENCY-1)'(vpfs_valid);
      cnt_reg        <= sum_next;
      cnt_sat_reg    <= sat_next;
      cnt_valid_reg  <= valid_pipe_reg[LATENCY-2];
      overflow_reg   <= valid_pipe_reg[LATENCY-2] && (sum_next > thresh);
    end
  end

  // A clear wins over the valid sample presented in the same cycle.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      peak_reg       <= '0;
      ovf_events_reg <= '0;
    end else if (stats_clr) begin
      peak_reg       <= '0;
      ovf_events_reg <= '0;
    end else if (cnt_valid_reg) begin
      if (cnt_reg > peak_reg) peak_reg <= cnt_reg;
      if (overflow_reg && (ovf_events_reg != '1)) ovf_events_reg <= ovf_events_reg + EVT_W'(1);
    end
  end

  assign cnt        = cnt_reg;
  assign cnt_sat    = cnt_sat_reg;
  assign cnt_valid  = cnt_valid_reg;
  assign overflow   = overflow_reg;
  assign peak       = peak_reg;
  assign ovf_events = ovf_events_reg;

endmodule
